// File: rtl/md_pad_pkg.sv
// md_pad_pkg: shared constants for the Mega Drive pad responder and the DB9
// reader. Holds the button/pad bit positions, the 6-button phase limit and
// the idle-timeout cycle computation.
package md_pad_pkg;

  // btn vector bit positions (active-high)
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;

  // pad_out bit positions (active-low DB9 lines)
  localparam int PAD_UP    = 0;
  localparam int PAD_DOWN  = 1;
  localparam int PAD_LEFT  = 2;
  localparam int PAD_RIGHT = 3;
  localparam int PAD_TL    = 4;
  localparam int PAD_TR    = 5;

  localparam int MD_PHASE_MAX = 4;

  typedef logic [2:0] md_phase_t;

  // Number of clk_sys cycles of SELECT inactivity before the phase resets.
  function automatic int timeout_cycles(input int clk_hz, input int timeout_us);
    return (clk_hz / 1000000) * timeout_us;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: STAGES-flop synchroniser for an asynchronous level, plus one
// extra register for edge detection. Reset loads RST_VAL everywhere so no
// spurious edge is seen when reset is released.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_d            : asynchronous input level
//   o_q            : synchronised level
//   o_rise/o_fall  : one-cycle pulses on o_q edges (same cycle o_q changes)
// STAGES must be at least 2.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_d    <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_d    <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise =  o_q & ~r_d;
  assign o_fall = ~o_q &  r_d;

endmodule

// File: rtl/md_pad_responder.sv
// md_pad_responder: device side of a Mega Drive 3/6-button pad. The host
// drives SELECT (TH); this block answers on the active-low pad lines,
// counting SELECT falling edges to walk the 6-button sequence.
//   clk_sys, reset_n : clock, async active-low reset
//   sel_in           : raw SELECT from the host (asynchronous)
//   six_btn_en       : 1 = 6-button sequence, 0 = plain 3-button pad
//   btn[11:0]        : active-high {Mode,X,Y,Z,Start,C,B,A,Up,Down,Left,Right}
//   pad_out[5:0]     : active-low {TR,TL,Right,Left,Down,Up}, registered
//   phase[2:0]       : falling-edge count 0..4 (debug)
//   timeout_pulse    : one cycle when SELECT idle time resets the phase
module md_pad_responder
  import md_pad_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int TIMEOUT_US  = 1500,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        sel_in,
  input  logic        six_btn_en,
  input  logic [11:0] btn,
  output logic [5:0]  pad_out,
  output logic [2:0]  phase,
  output logic        timeout_pulse
);

  localparam int              TERM   = timeout_cycles(CLK_HZ, TIMEOUT_US);
  localparam int              CW     = $clog2(TERM + 1);
  localparam logic [CW-1:0]   TERM_V = CW'(TERM);
  localparam md_phase_t       PH_MAX = md_phase_t'(MD_PHASE_MAX);

  logic            w_sel_s, w_rise, w_fall, w_edge, w_term_hit;
  md_phase_t       w_phase_nxt;
  logic [5:0]      w_pad_nxt;

  logic [CW-1:0]   r_idle;
  md_phase_t       r_phase;
  logic [5:0]      r_pad;
  logic            r_pulse;

  sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sel_sync (
    .i_clk  (clk_sys),
    .i_rst_n(reset_n),
    .i_d    (sel_in),
    .o_q    (w_sel_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_edge     = w_rise | w_fall;
  // An edge in the terminal cycle clears the counter instead, so no pulse.
  assign w_term_hit = !w_edge && (r_idle == TERM_V - CW'(1));

  always_comb begin
    w_phase_nxt = r_phase;
    if (!six_btn_en)
      w_phase_nxt = '0;
    else if (w_fall)
      w_phase_nxt = (r_phase == PH_MAX) ? PH_MAX : r_phase + 3'd1;
    else if (w_term_hit)
      w_phase_nxt = '0;
  end

  // Output table indexed by the synchronised SELECT and the updated phase.
  always_comb begin
    w_pad_nxt = '1;
    if (w_sel_s) begin
      if (w_phase_nxt == 3'd3) begin
        w_pad_nxt[PAD_TR]    = 1'b1;
        w_pad_nxt[PAD_TL]    = 1'b1;
        w_pad_nxt[PAD_RIGHT] = ~btn[BTN_MODE];
        w_pad_nxt[PAD_LEFT]  = ~btn[BTN_X];
        w_pad_nxt[PAD_DOWN]  = ~btn[BTN_Y];
        w_pad_nxt[PAD_UP]    = ~btn[BTN_Z];
      end else begin
        w_pad_nxt[PAD_TR]    = ~btn[BTN_C];
        w_pad_nxt[PAD_TL]    = ~btn[BTN_B];
        w_pad_nxt[PAD_RIGHT] = ~btn[BTN_RIGHT];
        w_pad_nxt[PAD_LEFT]  = ~btn[BTN_LEFT];
        w_pad_nxt[PAD_DOWN]  = ~btn[BTN_DOWN];
        w_pad_nxt[PAD_UP]    = ~btn[BTN_UP];
      end
    end else begin
      w_pad_nxt[PAD_TR] = ~btn[BTN_START];
      w_pad_nxt[PAD_TL] = ~btn[BTN_A];
      case (w_phase_nxt)
        3'd3: begin  // 6-button ID: directions all low
          w_pad_nxt[PAD_RIGHT] = 1'b0;
          w_pad_nxt[PAD_LEFT]  = 1'b0;
          w_pad_nxt[PAD_DOWN]  = 1'b0;
          w_pad_nxt[PAD_UP]    = 1'b0;
        end
        3'd4: begin
          w_pad_nxt[PAD_RIGHT] = 1'b1;
          w_pad_nxt[PAD_LEFT]  = 1'b1;
          w_pad_nxt[PAD_DOWN]  = 1'b1;
          w_pad_nxt[PAD_UP]    = 1'b1;
        end
        default: begin  // 3-button pad ID: Left/Right low
          w_pad_nxt[PAD_RIGHT] = 1'b0;
          w_pad_nxt[PAD_LEFT]  = 1'b0;
          w_pad_nxt[PAD_DOWN]  = ~btn[BTN_DOWN];
          w_pad_nxt[PAD_UP]    = ~btn[BTN_UP];
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_idle  <= '0;
      r_phase <= '0;
      r_pad   <= '1;
      r_pulse <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_pad   <= w_pad_nxt;
      r_pulse <= w_term_hit;
      // Saturates at the terminal count so the pulse fires only once.
      if (w_edge)
        r_idle <= '0;
      else if (r_idle != TERM_V)
        r_idle <= r_idle + CW'(1);
    end
  end

  assign pad_out       = r_pad;
  assign phase         = r_phase;
  assign timeout_pulse = r_pulse;

endmodule

// File: tb/tb_md_pad_responder.sv
module tb_md_pad_responder;

  localparam int CLK_HZ = 50000000;
  localparam int TO_US  = 10;
  localparam int NS     = 2;
  localparam int TERM   = 500;   // (CLK_HZ/1e6)*TO_US

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        sel_in;
  logic        six_btn_en;
  logic [11:0] btn;
  logic [5:0]  pad_out;
  logic [2:0]  phase;
  logic        timeout_pulse;

  always #10 clk_sys = ~clk_sys;

  md_pad_responder #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TO_US),
    .SYNC_STAGES(NS)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .sel_in       (sel_in),
    .six_btn_en   (six_btn_en),
    .btn          (btn),
    .pad_out      (pad_out),
    .phase        (phase),
    .timeout_pulse(timeout_pulse)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The device sees sel_in NS cycles late; the pad answers from a lookup of
  // (seen SELECT, falling edges since the last reset/timeout, buttons).
  logic       hist [0:NS];   // hist[i]: sel_in sampled i+1 clocks ago
  int         m_cyc, m_last, m_phase;
  logic [5:0] m_pad;
  logic       m_pulse;

  function automatic logic [5:0] pad_tbl(input logic s, input int ph, input logic [11:0] b);
    if (s) begin
      if (ph == 3) return {2'b11, ~b[11], ~b[10], ~b[9], ~b[8]};
      return {~b[6], ~b[5], ~b[0], ~b[1], ~b[2], ~b[3]};
    end
    if (ph == 3) return {~b[7], ~b[4], 4'b0000};
    if (ph == 4) return {~b[7], ~b[4], 4'b1111};
    return {~b[7], ~b[4], 2'b00, ~b[2], ~b[3]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= NS; i++) hist[i] = 1'b1;
    m_phase = 0;
    m_pad   = 6'h3F;
    m_pulse = 1'b0;
    m_last  = m_cyc;
  endtask

  task automatic model_step();
    logic s, d, e, fall, tmo;
    m_cyc++;
    if (!reset_n) begin
      model_reset();
      return;
    end
    s    = hist[NS-1];
    d    = hist[NS];
    e    = (s != d);
    fall = d && !s;
    tmo  = !e && (m_cyc - m_last == TERM);
    if (e) m_last = m_cyc;
    if (!six_btn_en)  m_phase = 0;
    else if (fall)    m_phase = (m_phase < 4) ? m_phase + 1 : 4;
    else if (tmo)     m_phase = 0;
    m_pulse = tmo;
    m_pad   = pad_tbl(s, m_phase, btn);
    for (int i = NS; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sel_in;
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_step();
    #1;
    chk("model_pad", pad_out, m_pad);
    chk("model_phase", phase, m_phase);
    chk("model_tmo", timeout_pulse, m_pulse);
    if (timeout_pulse === 1'b1) pulses++;
  endtask

  task automatic hold(input logic s, input int n);
    sel_in = s;
    repeat (n) step();
  endtask

  task automatic do_reset();
    #3;
    reset_n = 1'b0;
    sel_in  = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
  endtask

  typedef struct {
    logic        en;
    logic        sel;
    logic [11:0] b;
    logic [5:0]  exp;
  } vec_t;

  vec_t vt[7];
  logic [5:0] exp_lo[4], exp_hi[4];

  initial begin
    #1900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m_cyc = 0;
    model_reset();
    reset_n = 1'b0; sel_in = 1'b1; six_btn_en = 1'b0; btn = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("rst_pad", pad_out, 6'h3F);
    chk("rst_phase", phase, 0);
    chk("rst_tmo", timeout_pulse, 0);
    btn = 12'h028;  // Up + B
    step();
    chk("upb_pad", pad_out, 6'b101110);

    // ---- static table (phase stays 0 with six_btn_en = 0) ----
    vt[0] = '{1'b0, 1'b1, 12'h028, 6'b101110};
    vt[1] = '{1'b0, 1'b1, 12'h041, 6'b010111};
    vt[2] = '{1'b0, 1'b1, 12'hFFF, 6'b000000};
    vt[3] = '{1'b0, 1'b1, 12'hF00, 6'b111111};
    vt[4] = '{1'b0, 1'b0, 12'h090, 6'b000011};
    vt[5] = '{1'b0, 1'b0, 12'h00C, 6'b110000};
    vt[6] = '{1'b0, 1'b0, 12'h000, 6'b110011};
    for (int i = 0; i < 7; i++) begin
      six_btn_en = vt[i].en; sel_in = vt[i].sel; btn = vt[i].b;
      repeat (NS + 2) step();
      chk($sformatf("tbl%0d_pad", i), pad_out, vt[i].exp);
      chk($sformatf("tbl%0d_phase", i), phase, 0);
    end

    // ---- latency: SELECT fall reaches pad_out after NS+1 clocks ----
    do_reset();
    six_btn_en = 1'b1; btn = '0;
    hold(1'b1, 5);
    sel_in = 1'b0;
    step(); chk("lat1_pad", pad_out, 6'b111111);
    step(); chk("lat2_pad", pad_out, 6'b111111);
    step(); chk("lat3_pad", pad_out, 6'b110011);

    // ---- 6-button sequence: A, Start, Z, Mode pressed ----
    exp_lo = '{6'b000011, 6'b000011, 6'b000000, 6'b001111};
    exp_hi = '{6'b111111, 6'b111111, 6'b110110, 6'b111111};
    do_reset();
    six_btn_en = 1'b1; btn = 12'h990;
    hold(1'b1, 10);
    for (int k = 0; k < 4; k++) begin
      hold(1'b0, 100);
      chk($sformatf("six_lo%0d_pad", k), pad_out, exp_lo[k]);
      chk($sformatf("six_lo%0d_phase", k), phase, k + 1);
      hold(1'b1, 100);
      chk($sformatf("six_hi%0d_pad", k), pad_out, exp_hi[k]);
    end
    // idle timeout
    pulses = 0;
    hold(1'b1, TERM + 5);
    chk("tmo_count", pulses, 1);
    chk("tmo_phase", phase, 0);
    hold(1'b0, 10);
    chk("tmo_next_pad", pad_out, 6'b000011);
    chk("tmo_next_phase", phase, 1);

    // ---- same pulses as a 3-button pad ----
    do_reset();
    six_btn_en = 1'b0; btn = 12'h990;
    hold(1'b1, 10);
    for (int k = 0; k < 4; k++) begin
      hold(1'b0, 100);
      chk($sformatf("three_lo%0d_pad", k), pad_out, 6'b000011);
      chk($sformatf("three_lo%0d_phase", k), phase, 0);
      hold(1'b1, 100);
    end

    // ---- edge coincident with the terminal count ----
    do_reset();
    six_btn_en = 1'b1; btn = '0;
    hold(1'b0, 10);                 // phase 1
    pulses = 0;
    hold(1'b1, TERM);               // rise seen TERM clocks before the fall
    hold(1'b0, 10);
    chk("coin_pulses", pulses, 0);
    chk("coin_phase", phase, 2);
    // one clock later: timeout fires first, then the fall counts as phase 1
    pulses = 0;
    hold(1'b1, TERM + 1);
    hold(1'b0, 10);
    chk("late_pulses", pulses, 1);
    chk("late_phase", phase, 1);

    // ---- asynchronous reset mid-frame at phase 3 ----
    do_reset();
    six_btn_en = 1'b1; btn = '0;
    hold(1'b0, 20); hold(1'b1, 20);
    hold(1'b0, 20); hold(1'b1, 20);
    hold(1'b0, 20);
    chk("mid_phase", phase, 3);
    chk("mid_pad", pad_out, 6'b110000);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_pad", pad_out, 6'h3F);
    chk("arst_phase", phase, 0);
    chk("arst_tmo", timeout_pulse, 0);
    sel_in = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    hold(1'b1, 5);
    hold(1'b0, 5);
    chk("post_rst_phase", phase, 1);
    chk("post_rst_pad", pad_out, 6'b110011);

    // ---- randomized run against the model ----
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int len;
      if ($urandom_range(0, 9) == 0) six_btn_en = ~six_btn_en;
      if ($urandom_range(0, 3) == 0) btn = 12'($urandom);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(TERM - 3, TERM + 3)
                                        : $urandom_range(1, 40);
      sel_in = ~sel_in;
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 15) == 0) btn = 12'($urandom);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
